jtag_tap_ctrl: RTL and testbench
================================

# jtag_tap_ctrl

IEEE 1149.1 TAP controller for the JTAG block. It runs the 16-state TAP state machine from TMS. It holds the instruction register and produces the Capture/Shift/Update strobes and register selects that drive the data registers: ID code register, bypass, and boundary scan. It also muxes the serial outputs of the selected register onto TDO on the falling edge of TCK. It sits directly upstream of the ID code register.

## Interface
- IR_WIDTH, 4, instruction register width (≥2)
- IDCODE_OP, 4'b0010, IDCODE opcode; reset/TLR value of IR
- EXTEST_OP, 4'b0000, EXTEST opcode
- SAMPLE_OP, 4'b0001, SAMPLE/PRELOAD opcode
- TCK  in  1  JTAG clock
- TRST  in  1  reset TRST, asynchronous, active-low
- TMS  in  1  mode select, sampled on posedge TCK
- TDI  in  1  serial data in, sampled on posedge TCK
- idcode_tdo  in  1  serial out of ID code register (its bit 0)
- bsr_tdo  in  1  serial out of boundary scan register
- ir_status  in  IR_WIDTH  status bits for Capture-IR (only used with macro)
- TDO  out  1  serial data out, changes on negedge TCK
- TDO_en  out  1  high while shifting, registered on negedge TCK
- CaptureDR, ShiftDR, UpdateDR  out  1 each  decoded from current state
- CaptureIR, ShiftIR, UpdateIR  out  1 each  decoded from current state
- TLR  out  1  high in Test-Logic-Reset
- sel_idcode, sel_bsr, sel_bypass  out  1 each  one-hot DR select decoded from IR
- ir  out  IR_WIDTH  active instruction
- state  out  4  current TAP state (debug)

## Operation
- States: TLR, RTI, SelDR, CapDR, ShDR, Ex1DR, PauseDR, Ex2DR, UpdDR, SelIR, CapIR, ShIR, Ex1IR, PauseIR, Ex2IR, UpdIR.
- Transitions on posedge TCK, given as TMS=0 / TMS=1:
  - TLR→RTI/TLR; RTI→RTI/SelDR; SelDR→CapDR/SelIR; SelIR→CapIR/TLR.
  - CapX→ShX/Ex1X; ShX→ShX/Ex1X; Ex1X→PauseX/UpdX; PauseX→PauseX/Ex2X; Ex2X→ShX/UpdX; UpdX→RTI/SelDR (X = DR or IR).
- TMS=1 for 5 consecutive posedges reaches TLR from any state.
- Strobes are combinational state decodes. Consumers act on the posedge that ends the state.
- IR shift register (ir_sr):
  - Posedge in CapIR loads capture pattern, LSBs 2'b01.
  - Posedge in ShIR: ir_sr <= {TDI, ir_sr[IR_WIDTH-1:1]}.
- ir loads ir_sr on the negedge of TCK while in UpdIR.
- ir is forced to IDCODE_OP on the negedge while in TLR.
- Decode:
  - IDCODE_OP → sel_idcode.
  - EXTEST_OP or SAMPLE_OP → sel_bsr.
  - All-ones and every unused opcode → sel_bypass.
  - Exactly one select is high at all times.
- Bypass register:
  - 1 bit.
  - Posedge in CapDR loads 0.
  - Posedge in ShDR with sel_bypass loads TDI.
- TDO mux source:
  - ShIR: ir_sr[0].
  - ShDR: the selected register's serial out (idcode_tdo, bsr_tdo, or bypass bit).
  - Registered on negedge.
- TDO_en is registered on negedge as (state==ShDR || state==ShIR). When TDO_en is low, TDO is 0.

## Timing
- Reset (TRST low, async):
  - state=TLR, ir=IDCODE_OP, ir_sr=0, bypass=0, TDO=0, TDO_en=0.
  - TLR=1, sel_idcode=1, all Capture/Shift/Update strobes 0.
- TRST asserted mid-shift aborts immediately. No Update occurs; ir is unchanged except forced to IDCODE_OP.
- TDO lags the posedge that entered ShX by half a TCK cycle. The first bit out is the captured LSB.
- A DR shift of N bits through bypass delays TDI by exactly 1 TCK.
- An IR change takes effect at the negedge in UpdIR. sel_* are valid before the next CapDR.
- Pause states hold ir_sr and the DRs. TDO_en drops at the first negedge in Ex1X.

## Configuration
- JTAG_TAP_IR_STATUS_EN defined: CapIR loads {ir_status[IR_WIDTH-1:2], 2'b01}.
- Not defined: CapIR loads {(IR_WIDTH-2)'b0, 2'b01} and ir_status is ignored. The port stays present.

## Test plan
- Reset: pulse TRST low mid-clock → state=TLR, ir=4'b0010, sel_idcode=1, TDO=0, TDO_en=0 with no TCK edge.
- Reset via TMS: from PauseDR, drive TMS=1 for 5 TCKs → state=TLR. With 4 TCKs → state is not TLR.
- IDCODE read:
  - TMS sequence 0,1,0,0 from TLR → CaptureDR asserted one cycle, then ShiftDR.
  - Drive idcode_tdo with 0x10001003 LSB first → TDO reproduces it on 32 negedges with TDO_en=1.
- IR load BYPASS:
  - Shift 4'b1111 through ShIR → first 2 TDO bits are 1,0 (LSB first; macro off).
  - After UpdIR, sel_bypass=1.
  - A DR shift of TDI pattern 1011 → TDO shows 0,1,0,1 (1-bit delay, captured 0 first).
- EXTEST/unused decode: load 4'b0000 → sel_bsr=1 and TDO follows bsr_tdo. Load 4'b0111 → sel_bypass=1.
- Abort: TRST low during ShIR after 2 of 4 bits → ir=IDCODE_OP, no UpdateIR pulse seen.

Source files
------------

// File: rtl/jtag_tap_ctrl.sv
// IEEE 1149.1 TAP controller: TAP state machine, instruction register, DR selects, bypass bit and TDO mux.
// Define JTAG_TAP_IR_STATUS_EN to capture ir_status[IR_WIDTH-1:2] into the IR during Capture-IR.
module jtag_tap_ctrl #(
   parameter int                  IR_WIDTH  = 4,
   parameter logic [IR_WIDTH-1:0] IDCODE_OP = 4'b0010,
   parameter logic [IR_WIDTH-1:0] EXTEST_OP = 4'b0000,
   parameter logic [IR_WIDTH-1:0] SAMPLE_OP = 4'b0001
) (
   input  logic                TCK,
   input  logic                TRST,
   input  logic                TMS,
   input  logic                TDI,
   input  logic                idcode_tdo,
   input  logic                bsr_tdo,
   input  logic [IR_WIDTH-1:0] ir_status,
   output logic                TDO,
   output logic                TDO_en,
   output logic                CaptureDR,
   output logic                ShiftDR,
   output logic                UpdateDR,
   output logic                CaptureIR,
   output logic                ShiftIR,
   output logic                UpdateIR,
   output logic                TLR,
   output logic                sel_idcode,
   output logic                sel_bsr,
   output logic                sel_bypass,
   output logic [IR_WIDTH-1:0] ir,
   output logic [3:0]          state
);

   localparam logic [3:0] ST_TLR     = 4'd0;
   localparam logic [3:0] ST_RTI     = 4'd1;
   localparam logic [3:0] ST_SEL_DR  = 4'd2;
   localparam logic [3:0] ST_CAP_DR  = 4'd3;
   localparam logic [3:0] ST_SH_DR   = 4'd4;
   localparam logic [3:0] ST_EX1_DR  = 4'd5;
   localparam logic [3:0] ST_PAU_DR  = 4'd6;
   localparam logic [3:0] ST_EX2_DR  = 4'd7;
   localparam logic [3:0] ST_UPD_DR  = 4'd8;
   localparam logic [3:0] ST_SEL_IR  = 4'd9;
   localparam logic [3:0] ST_CAP_IR  = 4'd10;
   localparam logic [3:0] ST_SH_IR   = 4'd11;
   localparam logic [3:0] ST_EX1_IR  = 4'd12;
   localparam logic [3:0] ST_PAU_IR  = 4'd13;
   localparam logic [3:0] ST_EX2_IR  = 4'd14;
   localparam logic [3:0] ST_UPD_IR  = 4'd15;

   logic [3:0]          state_reg, state_next;
   logic [IR_WIDTH-1:0] ir_sr_reg, ir_reg, ir_capture;
   logic                bypass_reg, tdo_reg, tdo_en_reg;
   logic                shifting, tdo_src;
   logic                unused_ir_status;

   // State register
   always_ff @(posedge TCK or negedge TRST) begin
      if (!TRST) state_reg <= ST_TLR;
      else       state_reg <= state_next;
   end

   // Next-state logic
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_TLR:    state_next = TMS ? ST_TLR    : ST_RTI;
         ST_RTI:    state_next = TMS ? ST_SEL_DR : ST_RTI;
         ST_SEL_DR: state_next = TMS ? ST_SEL_IR : ST_CAP_DR;
         ST_CAP_DR: state_next = TMS ? ST_EX1_DR : ST_SH_DR;
         ST_SH_DR:  state_next = TMS ? ST_EX1_DR : ST_SH_DR;
         ST_EX1_DR: state_next = TMS ? ST_UPD_DR : ST_PAU_DR;
         ST_PAU_DR: state_next = TMS ? ST_EX2_DR : ST_PAU_DR;
         ST_EX2_DR: state_next = TMS ? ST_UPD_DR : ST_SH_DR;
         ST_UPD_DR: state_next = TMS ? ST_SEL_DR : ST_RTI;
         ST_SEL_IR: state_next = TMS ? ST_TLR    : ST_CAP_IR;
         ST_CAP_IR: state_next = TMS ? ST_EX1_IR : ST_SH_IR;
         ST_SH_IR:  state_next = TMS ? ST_EX1_IR : ST_SH_IR;
         ST_EX1_IR: state_next = TMS ? ST_UPD_IR : ST_PAU_IR;
         ST_PAU_IR: state_next = TMS ? ST_EX2_IR : ST_PAU_IR;
         ST_EX2_IR: state_next = TMS ? ST_UPD_IR : ST_SH_IR;
         ST_UPD_IR: state_next = TMS ? ST_SEL_DR : ST_RTI;
         default:   state_next = ST_TLR;
      endcase
   end

   // Strobes are pure state decodes; consumers act on the posedge that leaves the state
   always_comb begin
      CaptureDR = (state_reg == ST_CAP_DR);
      ShiftDR   = (state_reg == ST_SH_DR);
      UpdateDR  = (state_reg == ST_UPD_DR);
      CaptureIR = (state_reg == ST_CAP_IR);
      ShiftIR   = (state_reg == ST_SH_IR);
      UpdateIR  = (state_reg == ST_UPD_IR);
      TLR       = (state_reg == ST_TLR);
   end

   always_comb begin
      ir_capture      = '0;
      ir_capture[1:0] = 2'b01;
`ifdef JTAG_TAP_IR_STATUS_EN
      for (int i = 2; i < IR_WIDTH; i++) ir_capture[i] = ir_status[i];
`endif
   end

   assign unused_ir_status = ^ir_status;

   always_ff @(posedge TCK or negedge TRST) begin
      if (!TRST)                     ir_sr_reg <= '0;
      else if (state_reg == ST_CAP_IR) ir_sr_reg <= ir_capture;
      else if (state_reg == ST_SH_IR)  ir_sr_reg <= {TDI, ir_sr_reg[IR_WIDTH-1:1]};
   end

   // Active instruction changes on the falling edge so selects are stable by the next posedge
   always_ff @(negedge TCK or negedge TRST) begin
      if (!TRST)                       ir_reg <= IDCODE_OP;
      else if (state_reg == ST_TLR)    ir_reg <= IDCODE_OP;
      else if (state_reg == ST_UPD_IR) ir_reg <= ir_sr_reg;
   end

   always_comb begin
      sel_idcode = (ir_reg == IDCODE_OP);
      sel_bsr    = !sel_idcode && ((ir_reg == EXTEST_OP) || (ir_reg == SAMPLE_OP));
      sel_bypass = !sel_idcode && !sel_bsr;
   end

   always_ff @(posedge TCK or negedge TRST) begin
      if (!TRST)                                   bypass_reg <= 1'b0;
      else if (state_reg == ST_CAP_DR)             bypass_reg <= 1'b0;
      else if (state_reg == ST_SH_DR && sel_bypass) bypass_reg <= TDI;
   end

   assign shifting = (state_reg == ST_SH_DR) || (state_reg == ST_SH_IR);

   always_comb begin
      tdo_src = 1'b0;
      if (state_reg == ST_SH_IR)  tdo_src = ir_sr_reg[0];
      else if (sel_idcode)        tdo_src = idcode_tdo;
      else if (sel_bsr)           tdo_src = bsr_tdo;
      else                        tdo_src = bypass_reg;
   end

   always_ff @(negedge TCK or negedge TRST) begin
      if (!TRST) begin
         tdo_reg    <= 1'b0;
         tdo_en_reg <= 1'b0;
      end else begin
         tdo_reg    <= shifting & tdo_src;
         tdo_en_reg <= shifting;
      end
   end

   assign TDO    = tdo_reg;
   assign TDO_en = tdo_en_reg;
   assign ir     = ir_reg;
   assign state  = state_reg;

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// Directed bench for jtag_tap_ctrl (default build, IR status capture disabled).
module tb_jtag_tap_ctrl;

   logic       TCK, TRST, TMS, TDI, idcode_tdo, bsr_tdo;
   logic [3:0] ir_status;
   logic       TDO, TDO_en, CaptureDR, ShiftDR, UpdateDR, CaptureIR, ShiftIR, UpdateIR, TLR;
   logic       sel_idcode, sel_bsr, sel_bypass;
   logic [3:0] ir, state;

   int n_checks = 0;
   int n_pass   = 0;
   int upd_ir_cnt = 0;

   jtag_tap_ctrl dut (
      .TCK(TCK), .TRST(TRST), .TMS(TMS), .TDI(TDI),
      .idcode_tdo(idcode_tdo), .bsr_tdo(bsr_tdo), .ir_status(ir_status),
      .TDO(TDO), .TDO_en(TDO_en),
      .CaptureDR(CaptureDR), .ShiftDR(ShiftDR), .UpdateDR(UpdateDR),
      .CaptureIR(CaptureIR), .ShiftIR(ShiftIR), .UpdateIR(UpdateIR),
      .TLR(TLR), .sel_idcode(sel_idcode), .sel_bsr(sel_bsr), .sel_bypass(sel_bypass),
      .ir(ir), .state(state)
   );

   initial TCK = 1'b0;
   always #5 TCK = ~TCK;

   always @(posedge UpdateIR) upd_ir_cnt++;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // Drive TMS/TDI just after a posedge and advance to just after the next posedge
   task automatic tick(input logic tms, input logic tdi);
      TMS = tms;
      TDI = tdi;
      @(posedge TCK);
      #1;
   endtask

   // Same as tick, but also samples TDO/TDO_en just after the intervening negedge
   task automatic shift_bit(input logic tms, input logic tdi, input logic id_bit, input logic bsr_bit,
                            output logic tdo, output logic en);
      TMS = tms;
      TDI = tdi;
      idcode_tdo = id_bit;
      bsr_tdo = bsr_bit;
      @(negedge TCK);
      #1;
      tdo = TDO;
      en  = TDO_en;
      @(posedge TCK);
      #1;
   endtask

   // RTI -> shift 4-bit IR value -> RTI; returns the bits seen on TDO and UpdateIR seen in UpdIR
   task automatic ir_load(input logic [3:0] v, output logic [3:0] tdo_bits, output logic upd_seen);
      logic en;
      tick(1'b1, 1'b0);
      tick(1'b1, 1'b0);
      tick(1'b0, 1'b0);
      tick(1'b0, 1'b0);
      for (int i = 0; i < 4; i++) shift_bit(i == 3, v[i], 1'b0, 1'b0, tdo_bits[i], en);
      tick(1'b1, 1'b0);
      upd_seen = UpdateIR;
      tick(1'b0, 1'b0);
   endtask

   // RTI -> 4-bit DR shift -> RTI; idcode_tdo is driven opposite to bsr_tdo to expose a wrong mux pick
   task automatic dr_shift4(input logic [3:0] tdi_bits, input logic [3:0] bsr_bits, output logic [3:0] tdo_bits);
      logic en;
      tick(1'b1, 1'b0);
      tick(1'b0, 1'b0);
      tick(1'b0, 1'b0);
      for (int i = 0; i < 4; i++)
         shift_bit(i == 3, tdi_bits[i], ~bsr_bits[i], bsr_bits[i], tdo_bits[i], en);
      tick(1'b1, 1'b0);
      tick(1'b0, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] id_val, id_got;
      logic [3:0]  bits;
      logic        t, en, upd;
      int          en_cnt;

      TRST = 1'b1; TMS = 1'b1; TDI = 1'b0; idcode_tdo = 1'b0; bsr_tdo = 1'b0; ir_status = 4'hA;
      #2 TRST = 1'b0;
      #2;
      check_eq("rst_state", state, 4'd0);
      check_eq("rst_ir", ir, 4'b0010);
      check_eq("rst_tlr", TLR, 1);
      check_eq("rst_sel", {sel_idcode, sel_bsr, sel_bypass}, 3'b100);
      check_eq("rst_tdo", {TDO, TDO_en}, 2'b00);
      check_eq("rst_strobes", {CaptureDR, ShiftDR, UpdateDR, CaptureIR, ShiftIR, UpdateIR}, 6'b0);
      @(posedge TCK);
      #1 TRST = 1'b1;

      // IDCODE read
      tick(1'b0, 1'b0); check_eq("to_rti", state, 4'd1);
      tick(1'b1, 1'b0); check_eq("to_seldr", state, 4'd2);
      tick(1'b0, 1'b0); check_eq("capdr_strobe", {CaptureDR, ShiftDR}, 2'b10);
      tick(1'b0, 1'b0); check_eq("shdr_strobe", {CaptureDR, ShiftDR}, 2'b01);
      id_val = 32'h1000_1003;
      en_cnt = 0;
      for (int i = 0; i < 32; i++) begin
         shift_bit(i == 31, 1'b0, id_val[i], ~id_val[i], id_got[i], en);
         if (en) en_cnt++;
      end
      check_eq("idcode_tdo", id_got, 32'h1000_1003);
      check_eq("idcode_en_cnt", en_cnt, 32);
      check_eq("at_ex1dr", state, 4'd5);
      shift_bit(1'b1, 1'b0, 1'b0, 1'b0, t, en);
      check_eq("ex1dr_en_drop", {t, en}, 2'b00);
      tick(1'b0, 1'b0); check_eq("back_rti", state, 4'd1);

      // Load BYPASS (all ones)
      ir_load(4'b1111, bits, upd);
      check_eq("ir_cap_lsbs", bits[1:0], 2'b01);
      check_eq("ir_cap_all", bits, 4'b0001);
      check_eq("updir_strobe", upd, 1);
      check_eq("ir_bypass", ir, 4'b1111);
      check_eq("sel_bypass", {sel_idcode, sel_bsr, sel_bypass}, 3'b001);
      dr_shift4(4'b1101, 4'b0000, bits);
      check_eq("bypass_delay", bits, 4'b1010);

      // EXTEST / SAMPLE / unused decode
      ir_load(4'b0000, bits, upd);
      check_eq("sel_extest", {sel_idcode, sel_bsr, sel_bypass}, 3'b010);
      dr_shift4(4'b0000, 4'b1011, bits);
      check_eq("bsr_tdo", bits, 4'b1011);
      ir_load(4'b0001, bits, upd);
      check_eq("sel_sample", {sel_idcode, sel_bsr, sel_bypass}, 3'b010);
      ir_load(4'b0111, bits, upd);
      check_eq("sel_unused", {sel_idcode, sel_bsr, sel_bypass}, 3'b001);

      // TMS reset from PauseDR: 4 ones is not enough, the 5th reaches TLR
      tick(1'b1, 1'b0);
      tick(1'b0, 1'b0);
      tick(1'b1, 1'b0);
      tick(1'b0, 1'b0); check_eq("at_pausedr", state, 4'd6);
      tick(1'b0, 1'b0); check_eq("pausedr_hold", state, 4'd6);
      for (int i = 0; i < 4; i++) tick(1'b1, 1'b0);
      check_eq("tms4_not_tlr", state, 4'd9);
      tick(1'b1, 1'b0); check_eq("tms5_tlr", {state, TLR}, {4'd0, 1'b1});
      tick(1'b1, 1'b0); check_eq("tlr_forces_ir", ir, 4'b0010);

      // Abort an IR shift after 2 bits with TRST
      tick(1'b0, 1'b0);
      ir_load(4'b0111, bits, upd);
      check_eq("ir_before_abort", ir, 4'b0111);
      tick(1'b1, 1'b0);
      tick(1'b1, 1'b0);
      tick(1'b0, 1'b0);
      tick(1'b0, 1'b0);
      shift_bit(1'b0, 1'b0, 1'b0, 1'b0, t, en);
      shift_bit(1'b0, 1'b0, 1'b0, 1'b0, t, en);
      check_eq("abort_in_shir", {state, TDO_en}, {4'd11, 1'b1});
      TRST = 1'b0;
      #1;
      check_eq("abort_state", state, 4'd0);
      check_eq("abort_ir", ir, 4'b0010);
      check_eq("abort_tdo", {TDO, TDO_en, ShiftIR}, 3'b000);
      check_eq("abort_sel", {sel_idcode, sel_bsr, sel_bypass}, 3'b100);
      #1 TRST = 1'b1;
      tick(1'b1, 1'b0);
      tick(1'b1, 1'b0);
      check_eq("abort_stays_tlr", state, 4'd0);
      check_eq("updir_pulses", upd_ir_cnt, 5);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
